// File: rtl/inport_capture_pkg.sv
// rtl/inport_capture_pkg.sv - register map and shared types for the memory-mapped input port.
package inport_capture_pkg;

   localparam logic [7:0] DEFAULT_ADDR = 8'h01;

   localparam logic [7:0] OFS_DATA = 8'd0;
   localparam logic [7:0] OFS_CAP  = 8'd1;
   localparam logic [7:0] OFS_MASK = 8'd2;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_DATA,
      SEL_CAP,
      SEL_MASK
   } reg_sel_t;

   // Offsets wrap within the 8-bit bus address space.
   function automatic reg_sel_t decode(input logic [7:0] address, input logic [7:0] base);
      logic [7:0] ofs;
      ofs = address - base;
      case (ofs)
         OFS_DATA: decode = SEL_DATA;
         OFS_CAP:  decode = SEL_CAP;
         OFS_MASK: decode = SEL_MASK;
         default:  decode = SEL_NONE;
      endcase
   endfunction

endpackage

// File: rtl/inport_capture_sync_edge.sv
// rtl/inport_capture_sync_edge.sv - pin synchroniser with previous-value flop and rising-edge output.
module sync_edge #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pins,
   output logic [WIDTH-1:0] sync,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] stage [SYNC_STAGES];
   logic [WIDTH-1:0] prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
         prev <= '0;
      end else begin
         stage[0] <= pins;
         for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
         prev <= stage[SYNC_STAGES-1];
      end
   end

   assign sync = stage[SYNC_STAGES-1];
   assign rise = sync & ~prev;

endmodule

// File: rtl/inport_capture.sv
// rtl/inport_capture.sv - input port: synchronised data, sticky clear-on-read edge flags, maskable irq.
module inport_capture
   import inport_capture_pkg::*;
#(
   parameter logic [7:0] ADDR        = DEFAULT_ADDR,
   parameter int         WIDTH       = 8,
   parameter int         SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       address,
   input  logic [7:0]       value_in,
   input  logic             wen,
   input  logic             ren,
   input  logic [WIDTH-1:0] port_in,
   output logic [7:0]       value_out,
   output logic             irq
);

   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] capture;
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] clr;
   logic [7:0]       rdata;
   reg_sel_t         sel;

   sync_edge #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk  (clk),
      .rst  (rst),
      .pins (port_in),
      .sync (sync),
      .rise (rise)
   );

   always_comb begin
      sel   = decode(address, ADDR);
      rdata = 8'h00;
      clr   = '0;
      if (ren) begin
         case (sel)
            SEL_DATA: rdata = 8'(sync);
            SEL_CAP: begin
               rdata = 8'(capture);
               clr   = capture;
            end
            SEL_MASK: rdata = 8'(mask);
            default:  rdata = 8'h00;
         endcase
      end
   end

   // Only the bits actually returned are cleared, so an edge landing on the read edge survives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         capture   <= '0;
         mask      <= '0;
         value_out <= 8'h00;
      end else begin
         capture   <= (capture & ~clr) | rise;
         value_out <= rdata;
         if (wen && sel == SEL_MASK) mask <= value_in[WIDTH-1:0];
      end
   end

   assign irq = |(capture & mask);

endmodule

// File: doc/inport_capture.md
# inport_capture

Memory-mapped input port for the processor's I/O bus, the read-side counterpart of the output port. Synchronises an external input bus and exposes it at a decoded address. Latches rising edges into sticky, clear-on-read flags and raises a maskable interrupt request. Presents a registered read value that is zero when not selected, so several ports can be OR-combined onto the processor input bus.

## Interface
- ADDR, 'h01: base address; data register at ADDR, capture register at ADDR+1, mask register at ADDR+2 (8-bit wrap).
- WIDTH, 8: pin/register width, 1..8; unused upper bits of value_out read 0.
- SYNC_STAGES, 2: synchroniser depth, ≥2.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- address  in  8  bus address, sampled with wen/ren.
- value_in  in  8  write data (mask register only).
- wen  in  1  write strobe, one cycle per write.
- ren  in  1  read strobe, one cycle per read.
- port_in  in  WIDTH  external asynchronous pins.
- value_out  out  8  registered read data.
- irq  out  1  OR of (capture & mask).

## Operation
- Sync chain: SYNC_STAGES flops on port_in; its output is the data register `sync`. A further flop `prev` holds the previous `sync`.
- Edge detect: `rise = sync & ~prev`. Each set bit sets the matching capture bit.
- Reset: all sync flops, prev, capture and mask are 0; value_out is 0; irq is 0. A pin held high across reset release is therefore seen as a rising edge and sets its capture bit. This is intended.
- Read, ren=1 at edge t:
  - address==ADDR: value_out ← sync.
  - address==ADDR+1: value_out ← capture, and the returned bits are cleared.
  - address==ADDR+2: value_out ← mask.
  - Any other address: value_out ← 0.
- ren=0 at edge t: value_out ← 0.
- Capture update per edge: capture ← (capture & ~clr) | rise, where clr is the capture value returned by a read of ADDR+1 that cycle, else 0. A new edge coinciding with a clearing read leaves its bit set; no edge is lost.
- Write: wen=1 and address==ADDR+2 at edge t: mask ← value_in[WIDTH-1:0]. Writes to any other address are ignored.
- wen and ren in the same cycle are processed independently. A read of the mask during a mask write returns the old mask.
- irq is combinational from registered capture and mask. It stays high until the flagged bits are cleared or masked.
- Reset asserted mid-operation clears all state immediately, regardless of clk.

## Timing
- Pin change settled before edge k: sync updates at edge k+SYNC_STAGES-1, capture bit set at edge k+SYNC_STAGES, irq high after that same edge.
- Read latency: 1 cycle. value_out is valid for exactly the cycle after the ren edge, then returns to 0.
- Mask write takes effect on irq after the write edge.
- Back-to-back reads are allowed on every cycle.

## Structure
- Shared package/include: register offsets OFS_DATA=0, OFS_CAP=1, OFS_MASK=2, plus the default ADDR.
- One sub-module, `sync_edge`: WIDTH-bit synchroniser plus prev flop and rise output, parameterised by SYNC_STAGES. The top level contains only decode, the capture/mask registers and read muxing.

## Test plan
- Reset, then ren at ADDR with port_in='h00 → value_out='h00; irq=0.
- Reset with port_in='h00. Set port_in='haa; after 2 cycles, read ADDR → value_out='haa. Read ADDR+1 → 'haa. Read ADDR+1 again → 'h00.
- Write mask 'h0f at ADDR+2, then drive port_in 'h00→'h05 → irq=1 two edges after the change. Read ADDR+1 → 'h05, and irq=0 the next cycle. With mask 'h0f, an edge on bit 7 leaves irq=0.
- Read ADDR+1 returning 'h01 on the same edge that bit 1 rises → value_out='h01; capture='h02 afterwards; a second read returns 'h02.
- Read address 'h10, and pulse ren with a mismatched address → value_out='h00. Writing 'h05 to 'h10 leaves mask unchanged.
- Assert rst asynchronously between edges while capture='hff and value_out is nonzero → all outputs and registers 0 immediately.
